alarm_trigger: RTL and testbench

- Decides when the alarm sounds.
- Compares the running clock time against the user-set alarm time once per second tick.
- Runs a ring / snooze / stop state machine and drives the level `o_Alarm_On`.
- `o_Alarm_On` feeds the downstream toggle stage, which turns it into the buzzer drive.
- Sits between the timekeeping counters and the buzzer driver.

---
 rtl/alarm_trigger_if.sv | 28 ++
 rtl/alarm_trigger.sv | 144 ++++++++++++++
 tb/tb_alarm_trigger.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: time/alarm inputs, user control pulses and alarm status outputs.
// master drives time and controls; slave (alarm_trigger) returns the status levels.
interface alarm_trigger_if;
  logic       i_Sec_Tick;
  logic [4:0] i_Hours;
  logic [5:0] i_Minutes;
  logic [5:0] i_Seconds;
  logic [4:0] i_Alarm_Hours;
  logic [5:0] i_Alarm_Minutes;
  logic       i_Alarm_Enable;
  logic       i_Snooze;
  logic       i_Stop;
  logic       o_Alarm_On;
  logic       o_Snoozing;
  logic [2:0] o_Snooze_Count;

  modport master (
    output i_Sec_Tick, i_Hours, i_Minutes, i_Seconds, i_Alarm_Hours, i_Alarm_Minutes,
           i_Alarm_Enable, i_Snooze, i_Stop,
    input  o_Alarm_On, o_Snoozing, o_Snooze_Count
  );

  modport slave (
    input  i_Sec_Tick, i_Hours, i_Minutes, i_Seconds, i_Alarm_Hours, i_Alarm_Minutes,
           i_Alarm_Enable, i_Snooze, i_Stop,
    output o_Alarm_On, o_Snoozing, o_Snooze_Count
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm ring/snooze/stop FSM: fires on the HH:MM:00 tick matching the alarm time.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise snooze is ignored.
module alarm_trigger #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  alarm_trigger_if.slave bus
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ring_cnt, ring_cnt_nxt, ring_inc;
  logic        alarm_on_q, alarm_on_nxt;
  logic        match;

  // Seconds==0 keeps a mid-minute enable or a stop inside the alarm minute from refiring
  assign match = bus.i_Sec_Tick && (bus.i_Hours == bus.i_Alarm_Hours) &&
                 (bus.i_Minutes == bus.i_Alarm_Minutes) && (bus.i_Seconds == 6'd0);
  assign ring_inc = ring_cnt + 16'd1;

`ifdef ALARM_SNOOZE_EN
  logic [15:0] snz_cnt, snz_cnt_nxt, snz_inc;
  logic [2:0]  snz_used, snz_used_nxt;
  logic        snoozing_q, snoozing_nxt;

  assign snz_inc = snz_cnt + 16'd1;
`else
  logic unused_snooze;
  assign unused_snooze = bus.i_Snooze;
`endif

  // State and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= DISABLED;
      ring_cnt   <= '0;
      alarm_on_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
      snz_used   <= '0;
      snoozing_q <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      ring_cnt   <= ring_cnt_nxt;
      alarm_on_q <= alarm_on_nxt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= snz_cnt_nxt;
      snz_used   <= snz_used_nxt;
      snoozing_q <= snoozing_nxt;
`endif
    end
  end

  // Next state; stop is checked before snooze, snooze before the tick
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt  = snz_cnt;
    snz_used_nxt = snz_used;
`endif
    if (!bus.i_Alarm_Enable) begin
      state_nxt    = DISABLED;
      ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_nxt  = '0;
      snz_used_nxt = '0;
`endif
    end else begin
      case (state)
        DISABLED: state_nxt = ARMED;
        ARMED: begin
          if (match) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end
        end
        RINGING: begin
          if (bus.i_Stop) begin
            state_nxt    = ARMED;
`ifdef ALARM_SNOOZE_EN
            snz_used_nxt = '0;
          end else if (bus.i_Snooze && (snz_used < 3'(MAX_SNOOZES))) begin
            state_nxt    = SNOOZE;
            snz_used_nxt = snz_used + 3'd1;
            snz_cnt_nxt  = '0;
`endif
          end else if (bus.i_Sec_Tick) begin
            ring_cnt_nxt = ring_inc;
            if (ring_inc == 16'(RING_TIMEOUT_S)) begin
              state_nxt    = ARMED;
`ifdef ALARM_SNOOZE_EN
              snz_used_nxt = '0;
`endif
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (bus.i_Stop) begin
            state_nxt    = ARMED;
            snz_used_nxt = '0;
          end else if (bus.i_Sec_Tick) begin
            snz_cnt_nxt = snz_inc;
            if (snz_inc == 16'(SNOOZE_S)) begin
              state_nxt    = RINGING;
              ring_cnt_nxt = '0;
            end
          end
        end
`endif
        default: state_nxt = DISABLED;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    alarm_on_nxt = (state_nxt == RINGING);
`ifdef ALARM_SNOOZE_EN
    snoozing_nxt = (state_nxt == SNOOZE);
`endif
  end

  assign bus.o_Alarm_On = alarm_on_q;
`ifdef ALARM_SNOOZE_EN
  assign bus.o_Snoozing     = snoozing_q;
  assign bus.o_Snooze_Count = snz_used;
`else
  assign bus.o_Snoozing     = 1'b0;
  assign bus.o_Snooze_Count = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger (RING=4, SNOOZE=3, MAX=2, alarm 07:30).
// Expectations follow ALARM_SNOOZE_EN the same way the build does.
module tb_alarm_trigger;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [4:0] obs;

  always #5 clk = ~clk;

  alarm_trigger_if bus ();

  alarm_trigger #(.RING_TIMEOUT_S(4), .SNOOZE_S(3), .MAX_SNOOZES(2)) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  // {alarm_on, snoozing, snooze_count}
  assign obs = {bus.o_Alarm_On, bus.o_Snoozing, bus.o_Snooze_Count};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    bus.i_Hours    = 5'(h);
    bus.i_Minutes  = 6'(m);
    bus.i_Seconds  = 6'(s);
    bus.i_Sec_Tick = 1'b1;
    cyc();
    bus.i_Sec_Tick = 1'b0;
  endtask

  task automatic pulse(input bit stop, input bit snz);
    bus.i_Stop   = stop;
    bus.i_Snooze = snz;
    cyc();
    bus.i_Stop   = 1'b0;
    bus.i_Snooze = 1'b0;
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus.i_Sec_Tick      = 1'b0;
    bus.i_Hours         = 5'd0;
    bus.i_Minutes       = 6'd0;
    bus.i_Seconds       = 6'd0;
    bus.i_Alarm_Hours   = 5'd7;
    bus.i_Alarm_Minutes = 6'd30;
    bus.i_Alarm_Enable  = 1'b1;
    bus.i_Snooze        = 1'b0;
    bus.i_Stop          = 1'b0;
    #23;
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL reset_state obs=%b exp=%b", obs, 5'b00000); end
    rst_n = 1'b1;
    cyc();
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL armed_idle obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_ring_timeout();
    tick_at(7, 29, 59);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL pre_match obs=%b exp=%b", obs, 5'b00000); end
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL ring_rise obs=%b exp=%b", obs, 5'b10000); end
    for (int s = 1; s <= 3; s++) tick_at(7, 30, s);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL ring_tick3 obs=%b exp=%b", obs, 5'b10000); end
    tick_at(7, 30, 4);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL ring_timeout obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_stop();
    bit seen;
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL stop_ring obs=%b exp=%b", obs, 5'b10000); end
    pulse(1'b1, 1'b0);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL stop_fall obs=%b exp=%b", obs, 5'b00000); end
    seen = 1'b0;
    for (int s = 1; s <= 59; s++) begin
      tick_at(7, 30, s);
      if (bus.o_Alarm_On !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL stop_no_retrigger seen=%b exp=%b", seen, 1'b0); end
  endtask

  task automatic test_snooze();
    tick_at(7, 30, 0);
`ifdef ALARM_SNOOZE_EN
    // snooze and tick together: snooze wins
    bus.i_Snooze = 1'b1;
    tick_at(7, 30, 1);
    bus.i_Snooze = 1'b0;
    checks++; if (obs !== 5'b01001) begin failures++; $display("FAIL snz1_enter obs=%b exp=%b", obs, 5'b01001); end
    tick_at(7, 30, 2);
    tick_at(7, 30, 3);
    checks++; if (obs !== 5'b01001) begin failures++; $display("FAIL snz1_wait obs=%b exp=%b", obs, 5'b01001); end
    tick_at(7, 30, 4);
    checks++; if (obs !== 5'b10001) begin failures++; $display("FAIL snz1_rering obs=%b exp=%b", obs, 5'b10001); end
    pulse(1'b0, 1'b1);
    checks++; if (obs !== 5'b01010) begin failures++; $display("FAIL snz2_enter obs=%b exp=%b", obs, 5'b01010); end
    for (int s = 5; s <= 7; s++) tick_at(7, 30, s);
    checks++; if (obs !== 5'b10010) begin failures++; $display("FAIL snz2_rering obs=%b exp=%b", obs, 5'b10010); end
    pulse(1'b0, 1'b1);
    checks++; if (obs !== 5'b10010) begin failures++; $display("FAIL snz3_ignored obs=%b exp=%b", obs, 5'b10010); end
    pulse(1'b1, 1'b0);
`else
    pulse(1'b0, 1'b1);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL snz_ignored obs=%b exp=%b", obs, 5'b10000); end
    for (int s = 1; s <= 3; s++) tick_at(7, 30, s);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL snz_off_tick3 obs=%b exp=%b", obs, 5'b10000); end
    tick_at(7, 30, 4);
`endif
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL snz_end obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_stop_and_snooze();
    tick_at(7, 30, 0);
`ifdef ALARM_SNOOZE_EN
    pulse(1'b0, 1'b1);
    for (int s = 1; s <= 3; s++) tick_at(7, 30, s);
    checks++; if (obs !== 5'b10001) begin failures++; $display("FAIL ss_rering obs=%b exp=%b", obs, 5'b10001); end
`endif
    pulse(1'b1, 1'b1);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL stop_wins obs=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_disable();
    tick_at(7, 30, 0);
`ifdef ALARM_SNOOZE_EN
    pulse(1'b0, 1'b1);
    checks++; if (obs !== 5'b01001) begin failures++; $display("FAIL dis_snoozing obs=%b exp=%b", obs, 5'b01001); end
`endif
    bus.i_Alarm_Enable = 1'b0;
    cyc();
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL dis_clear obs=%b exp=%b", obs, 5'b00000); end
    bus.i_Alarm_Enable = 1'b1;
    cyc();
    tick_at(7, 30, 1);
    tick_at(7, 31, 0);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL dis_no_ring obs=%b exp=%b", obs, 5'b00000); end
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL dis_rematch obs=%b exp=%b", obs, 5'b10000); end
    pulse(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_ring();
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL rst_ring obs=%b exp=%b", obs, 5'b10000); end
    rst_n = 1'b0;
    #1;
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL rst_async obs=%b exp=%b", obs, 5'b00000); end
    #5;
    rst_n = 1'b1;
    // first clock after release only leaves DISABLED, so this match is ignored
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b00000) begin failures++; $display("FAIL rst_first_clk obs=%b exp=%b", obs, 5'b00000); end
    tick_at(7, 30, 0);
    checks++; if (obs !== 5'b10000) begin failures++; $display("FAIL rst_rearm obs=%b exp=%b", obs, 5'b10000); end
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_stop();
    test_snooze();
    test_stop_and_snooze();
    test_disable();
    test_reset_mid_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
